soc_glip_channel_arbiter: RTL and testbench

//  N-to-1 multiplexer for GLIP valid/ready channels, with per-input FIFO buffering and round-robin burst arbitration.

---
 rtl/soc_glip_pkg.sv | 23 ++
 rtl/soc_glip_fifo.sv | 47 ++++
 rtl/soc_glip_channel_arbiter.sv | 78 +++++++
 tb/tb_soc_glip_channel_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_glip_pkg.sv
// soc_glip_pkg: shared arbiter state type and round-robin search helper
package soc_glip_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // First requesting channel after last, wrapping modulo nch; returns last if none request
    function automatic logic [3:0] next_rr(input logic [15:0] req, input logic [3:0] last, input int nch);
        logic [3:0] win;
        logic found;
        int idx;
        win = last;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = (int'(last) + i) % nch;
            if (!found && i <= nch && req[idx]) begin
                win = 4'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/soc_glip_fifo.sv
// soc_glip_fifo: first-word-fall-through FIFO buffering one input channel
module soc_glip_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       rd_en,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign wr      = wr_en && !full;
    assign rd      = rd_en && !empty;
    assign rd_data = mem[rp];

    // Storage needs no reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH; read+write together leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/soc_glip_channel_arbiter.sv
// soc_glip_channel_arbiter: merges NCH buffered channels onto one link with round-robin bursts
module soc_glip_channel_arbiter
    import soc_glip_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int DEPTH = 8,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*WIDTH-1:0]     in_data,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NCH)-1:0]   out_id,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = BURST > 1 ? $clog2(BURST) : 1;

    arb_state_t state;
    logic [IW-1:0] sel, last, win;
    logic [BW-1:0] beat;
    logic [NCH-1:0] empty, full, wr, rd;
    logic [WIDTH-1:0] head [NCH];
    logic [CW-1:0] cnt [NCH];
    logic xfer, last_word;

    assign in_ready  = rst ? '0 : ~full;
    assign wr        = in_valid & in_ready;
    assign out_valid = !rst && state == ARB_GRANT && !empty[sel];
    assign out_id    = out_valid ? sel : '0;
    assign out_data  = out_valid ? head[sel] : '0;
    assign xfer      = out_valid && out_ready;
    assign last_word = cnt[sel] == CW'(1) && !wr[sel];
    assign win       = IW'(next_rr(16'(~empty), 4'(last), NCH));

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign rd[i] = xfer && sel == IW'(i);
        soc_glip_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_data (in_data[i*WIDTH +: WIDTH]),
            .wr_en   (wr[i]),
            .full    (full[i]),
            .rd_data (head[i]),
            .rd_en   (rd[i]),
            .empty   (empty[i]),
            .count   (cnt[i])
        );
    end

    // Grant one channel for up to BURST words, then spend a bubble re-arbitrating
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            sel   <= '0;
            last  <= IW'(NCH - 1);
            beat  <= '0;
        end else if (state == ARB_IDLE) begin
            if (|(~empty)) begin
                sel   <= win;
                last  <= win;
                beat  <= '0;
                state <= ARB_GRANT;
            end
        end else if (xfer) begin
            beat <= beat + BW'(1);
            if (beat == BW'(BURST - 1) || last_word) state <= ARB_IDLE;
        end else if (empty[sel]) begin
            state <= ARB_IDLE;
        end
    end

endmodule

// File: tb/tb_soc_glip_channel_arbiter.sv
// tb_soc_glip_channel_arbiter: directed scenario tests for the channel arbiter
module tb_soc_glip_channel_arbiter;
    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam int BURST = 4;

    logic clk, rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0] in_valid, in_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0] out_id;
    logic out_valid, out_ready;
    int checks, failures;

    soc_glip_channel_arbiter #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        in_data = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '1;
        out_ready = 1'b1;
        in_data = '1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks += 2;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid); end
            if (in_ready !== 4'h0) begin failures++; $display("FAIL reset_in_ready cyc%0d: got %h want 0", c, in_ready); end
        end
        rst = 1'b0;
        in_valid = '0;
        #1;
        checks += 4;
        if (in_ready !== 4'hF) begin failures++; $display("FAIL release_in_ready: got %h want f", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
        if (out_data !== 16'h0) begin failures++; $display("FAIL release_out_data: got %h want 0", out_data); end
        if (out_id !== 2'd0) begin failures++; $display("FAIL release_out_id: got %0d want 0", out_id); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        set_data(2, 16'hA5A5);
        in_valid = 4'b0100;
        step();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_t1_valid: got %b want 0", out_valid); end
        step();
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_t2_valid: got %b want 1", out_valid); end
        if (out_data !== 16'hA5A5) begin failures++; $display("FAIL lat_t2_data: got %h want a5a5", out_data); end
        if (out_id !== 2'd2) begin failures++; $display("FAIL lat_t2_id: got %0d want 2", out_id); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_t3_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic ev[$];
        logic [1:0] eid[$];
        logic [WIDTH-1:0] ed[$];
        int nxt[NCH];
        int ch, n;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NCH; c++) set_data(c, 16'(c * 256 + k));
            in_valid = 4'hF;
            step();
        end
        in_valid = '0;
        for (int c = 0; c < NCH; c++) nxt[c] = 0;
        for (int g = 0; g < 8; g++) begin
            ch = g % NCH;
            n = g < 4 ? 4 : 2;
            for (int j = 0; j < n; j++) begin
                ev.push_back(1'b1);
                eid.push_back(2'(ch));
                ed.push_back(16'(ch * 256 + nxt[ch]));
                nxt[ch]++;
            end
            if (g < 7) begin
                ev.push_back(1'b0);
                eid.push_back(2'd0);
                ed.push_back(16'h0);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < ev.size(); c++) begin
            checks++;
            if (out_valid !== ev[c]) begin
                failures++;
                $display("FAIL rr_valid cyc%0d: got %b want %b", c, out_valid, ev[c]);
            end else if (ev[c]) begin
                checks += 2;
                if (out_id !== eid[c]) begin failures++; $display("FAIL rr_id cyc%0d: got %0d want %0d", c, out_id, eid[c]); end
                if (out_data !== ed[c]) begin failures++; $display("FAIL rr_data cyc%0d: got %h want %h", c, out_data, ed[c]); end
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_full_fifo();
        logic [WIDTH-1:0] got[$];
        logic acc;
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            set_data(1, 16'(16'h1000 + k));
            in_valid = 4'b0010;
            checks++;
            if (in_ready[1] !== 1'b1) begin failures++; $display("FAIL full_fill_ready w%0d: got %b want 1", k, in_ready[1]); end
            step();
        end
        set_data(1, 16'h1008);
        checks += 3;
        if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL full_ready_low: got %b want 0", in_ready[1]); end
        if (out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
        if (out_data !== 16'h1000) begin failures++; $display("FAIL full_head: got %h want 1000", out_data); end
        step();
        step();
        checks++;
        if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL full_held: got %b want 0", in_ready[1]); end
        out_ready = 1'b1;
        got.push_back(out_data);
        step();
        checks++;
        if (in_ready[1] !== 1'b1) begin failures++; $display("FAIL full_after_read_ready: got %b want 1", in_ready[1]); end
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_ready) got.push_back(out_data);
            acc = in_valid[1] && in_ready[1];
            step();
            if (acc) in_valid = '0;
        end
        checks++;
        if (got.size() != DEPTH + 1) begin failures++; $display("FAIL full_word_count: got %0d want %0d", got.size(), DEPTH + 1); end
        for (int k = 0; k < got.size() && k <= DEPTH; k++) begin
            checks++;
            if (got[k] !== 16'(16'h1000 + k)) begin failures++; $display("FAIL full_order w%0d: got %h want %h", k, got[k], 16'(16'h1000 + k)); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_d[8] = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h3B00, 16'h3B01, 16'h3B02, 16'h0A04};
        logic [1:0] exp_i[8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0};
        logic [WIDTH-1:0] gd[$];
        logic [1:0] gi[$];
        logic hold;
        logic [WIDTH-1:0] hd;
        logic [1:0] hid;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_data(0, 16'(16'h0A00 + k));
            set_data(3, 16'(16'h3B00 + k));
            in_valid = k < 3 ? 4'b1001 : 4'b0001;
            step();
        end
        in_valid = '0;
        hold = 1'b0;
        hd = '0;
        hid = '0;
        for (int c = 0; c < 200 && gd.size() < 8; c++) begin
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== hid || out_data !== hd) begin
                    failures++;
                    $display("FAIL bp_stable cyc%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h", c, out_valid, out_id, out_data, hid, hd);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            hold = out_valid && !out_ready;
            hid = out_id;
            hd = out_data;
            if (out_valid && out_ready) begin
                gd.push_back(out_data);
                gi.push_back(out_id);
            end
            step();
        end
        checks++;
        if (gd.size() != 8) begin failures++; $display("FAIL bp_word_count: got %0d want 8", gd.size()); end
        for (int k = 0; k < gd.size() && k < 8; k++) begin
            checks++;
            if (gd[k] !== exp_d[k] || gi[k] !== exp_i[k]) begin
                failures++;
                $display("FAIL bp_order w%0d: got id=%0d d=%h want id=%0d d=%h", k, gi[k], gd[k], exp_i[k], exp_d[k]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_data(2, 16'(16'h2C00 + k));
            in_valid = 4'b0100;
            step();
        end
        in_valid = '0;
        out_ready = 1'b1;
        checks += 2;
        if (out_valid !== 1'b1 || out_data !== 16'h2C00) begin failures++; $display("FAIL mrst_beat0: got v=%b d=%h want v=1 d=2c00", out_valid, out_data); end
        step();
        if (out_valid !== 1'b1 || out_data !== 16'h2C01) begin failures++; $display("FAIL mrst_beat1: got v=%b d=%h want v=1 d=2c01", out_valid, out_data); end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_during_valid: got %b want 0", out_valid); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_after_valid: got %b want 0", out_valid); end
        if (in_ready !== 4'hF) begin failures++; $display("FAIL mrst_after_ready: got %h want f", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_flushed: got %b want 0", out_valid); end
        set_data(0, 16'h0D00);
        set_data(1, 16'h1D00);
        set_data(3, 16'h3D00);
        in_valid = 4'b1011;
        step();
        in_valid = '0;
        step();
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL mrst_first_valid: got %b want 1", out_valid); end
        if (out_id !== 2'd0) begin failures++; $display("FAIL mrst_first_id: got %0d want 0", out_id); end
        if (out_data !== 16'h0D00) begin failures++; $display("FAIL mrst_first_data: got %h want 0d00", out_data); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_latency();
        test_round_robin();
        test_full_fifo();
        test_backpressure();
        test_mid_burst_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
